// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and common types for
// the controller and its counters.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_SYNC         = 96;
  localparam int unsigned VGA_H_ACTIVE_START = 144;
  localparam int unsigned VGA_H_ACTIVE_END   = 784;
  localparam int unsigned VGA_H_TOTAL        = 800;
  localparam int unsigned VGA_V_SYNC         = 2;
  localparam int unsigned VGA_V_ACTIVE_START = 35;
  localparam int unsigned VGA_V_ACTIVE_END   = 515;
  localparam int unsigned VGA_V_TOTAL        = 525;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_counter.sv
// Wrap counter: counts 0..LIMIT-1 while enabled, flagging the wrapping cycle
// so a second counter can be chained off it.
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned LIMIT = VGA_H_TOTAL
) (
  input  logic pclk,
  input  logic reset,
  input  logic en_i,
  output cnt_t cnt_o,
  output logic wrap_o
);

  localparam cnt_t LAST = cnt_t'(LIMIT - 1);

  cnt_t cnt_q;
  cnt_t cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: chained horizontal/vertical counters with purely
// combinational sync, blanking, address and colour decode.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC         = VGA_H_SYNC,
  parameter int unsigned H_ACTIVE_START = VGA_H_ACTIVE_START,
  parameter int unsigned H_ACTIVE_END   = VGA_H_ACTIVE_END,
  parameter int unsigned H_TOTAL        = VGA_H_TOTAL,
  parameter int unsigned V_SYNC         = VGA_V_SYNC,
  parameter int unsigned V_ACTIVE_START = VGA_V_ACTIVE_START,
  parameter int unsigned V_ACTIVE_END   = VGA_V_ACTIVE_END,
  parameter int unsigned V_TOTAL        = VGA_V_TOTAL
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_wrap;
  logic unused_v_wrap;
  logic h_valid;
  logic v_valid;
  rgb_t pix;

  vga_counter #(.LIMIT(H_TOTAL)) u_h_cnt (
    .pclk   (pclk),
    .reset  (reset),
    .en_i   (1'b1),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  // The vertical counter advances only on the last pixel of each line.
  vga_counter #(.LIMIT(V_TOTAL)) u_v_cnt (
    .pclk   (pclk),
    .reset  (reset),
    .en_i   (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (unused_v_wrap)
  );

  assign hsync   = (h_cnt >= cnt_t'(H_SYNC));
  assign vsync   = (v_cnt >= cnt_t'(V_SYNC));
  assign h_valid = (h_cnt >= cnt_t'(H_ACTIVE_START)) && (h_cnt < cnt_t'(H_ACTIVE_END));
  assign v_valid = (v_cnt >= cnt_t'(V_ACTIVE_START)) && (v_cnt < cnt_t'(V_ACTIVE_END));
  assign valid   = h_valid && v_valid;

  // Subtraction is gated by the region test, so it can never underflow.
  assign h_addr = h_valid ? (h_cnt - cnt_t'(H_ACTIVE_START)) : '0;
  assign v_addr = v_valid ? (v_cnt - cnt_t'(V_ACTIVE_START)) : '0;

  assign pix   = vga_data;
  assign vga_r = valid ? pix.r : 8'h00;
  assign vga_g = valid ? pix.g : 8'h00;
  assign vga_b = valid ? pix.b : 8'h00;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a default-timing instance and a shrunken-timing instance
// driven with random pixel data and compared against an arithmetic model.
module tb_vga_ctrl;
  import vga_pkg::*;

  localparam int SH_SYNC = 4;
  localparam int SH_AS   = 7;
  localparam int SH_AE   = 17;
  localparam int SH_TOT  = 20;
  localparam int SV_SYNC = 2;
  localparam int SV_AS   = 4;
  localparam int SV_AE   = 12;
  localparam int SV_TOT  = 15;

  localparam int LINE0 = 35 * 800;

  logic        pclk = 1'b0;
  logic        reset;
  logic [23:0] d_data, s_data;
  logic [9:0]  d_h_addr, d_v_addr, s_h_addr, s_v_addr;
  logic        d_hsync, d_vsync, d_valid, s_hsync, s_vsync, s_valid;
  logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;

  int n_cmp = 0;
  int n_err = 0;
  int t;

  int d_lo_len, d_last_fall;
  logic d_hs_prev;
  int s_vlo_len, s_last_fall, s_val_cnt;
  logic s_vs_prev, s_first_seen;
  logic [9:0] s_last_h, s_last_v;

  always #5 pclk = ~pclk;

  vga_ctrl u_dut (
    .pclk(pclk), .reset(reset), .vga_data(d_data),
    .h_addr(d_h_addr), .v_addr(d_v_addr), .hsync(d_hsync), .vsync(d_vsync),
    .valid(d_valid), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
  );

  vga_ctrl #(
    .H_SYNC(SH_SYNC), .H_ACTIVE_START(SH_AS), .H_ACTIVE_END(SH_AE), .H_TOTAL(SH_TOT),
    .V_SYNC(SV_SYNC), .V_ACTIVE_START(SV_AS), .V_ACTIVE_END(SV_AE), .V_TOTAL(SV_TOT)
  ) u_small (
    .pclk(pclk), .reset(reset), .vga_data(s_data),
    .h_addr(s_h_addr), .v_addr(s_v_addr), .hsync(s_hsync), .vsync(s_vsync),
    .valid(s_valid), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Position follows directly from cycles elapsed since reset release.
  function automatic logic [63:0] model(input int cyc, input int hs, input int has,
                                        input int hae, input int ht, input int vs,
                                        input int vas, input int vae, input int vt,
                                        input logic [23:0] data);
    int h, v;
    logic hv, vv, val;
    logic [9:0] ha, va;
    h   = cyc % ht;
    v   = (cyc / ht) % vt;
    hv  = (h >= has) && (h < hae);
    vv  = (v >= vas) && (v < vae);
    val = hv && vv;
    ha  = hv ? 10'(h - has) : 10'd0;
    va  = vv ? 10'(v - vas) : 10'd0;
    return 64'({h >= hs, v >= vs, val, ha, va, val ? data : 24'h0});
  endfunction

  task automatic init_meas();
    d_hs_prev = 1'b0; d_lo_len = 0; d_last_fall = -1;
    s_vs_prev = 1'b0; s_vlo_len = 0; s_last_fall = -1; s_val_cnt = 0;
    s_first_seen = 1'b0; s_last_h = '0; s_last_v = '0;
  endtask

  task automatic measure();
    if (!d_hsync) d_lo_len++;
    if (!d_hs_prev && d_hsync) begin
      check("hsync_low_len", 64'(d_lo_len), 64'(VGA_H_SYNC));
      d_lo_len = 0;
    end
    if (d_hs_prev && !d_hsync) begin
      if (d_last_fall >= 0) check("hsync_period", 64'(t - d_last_fall), 64'(VGA_H_TOTAL));
      d_last_fall = t;
    end
    d_hs_prev = d_hsync;

    if (s_vs_prev && !s_vsync) begin
      if (s_last_fall >= 0) check("vsync_period", 64'(t - s_last_fall), 64'(SH_TOT * SV_TOT));
      s_last_fall = t;
      check("valid_per_frame", 64'(s_val_cnt), 64'((SH_AE - SH_AS) * (SV_AE - SV_AS)));
      check("last_addr", 64'({s_last_h, s_last_v}),
            64'({10'(SH_AE - SH_AS - 1), 10'(SV_AE - SV_AS - 1)}));
      s_val_cnt = 0;
      s_first_seen = 1'b0;
    end
    if (!s_vsync) s_vlo_len++;
    if (!s_vs_prev && s_vsync) begin
      check("vsync_low_len", 64'(s_vlo_len), 64'(SV_SYNC * SH_TOT));
      s_vlo_len = 0;
    end
    s_vs_prev = s_vsync;

    if (s_valid) begin
      s_val_cnt++;
      if (!s_first_seen) check("first_addr", 64'({s_h_addr, s_v_addr}), 64'(0));
      s_first_seen = 1'b1;
      s_last_h = s_h_addr;
      s_last_v = s_v_addr;
    end
  endtask

  task automatic sample();
    check("dflt_outs",
          64'({d_hsync, d_vsync, d_valid, d_h_addr, d_v_addr, d_r, d_g, d_b}),
          model(t, VGA_H_SYNC, VGA_H_ACTIVE_START, VGA_H_ACTIVE_END, VGA_H_TOTAL,
                VGA_V_SYNC, VGA_V_ACTIVE_START, VGA_V_ACTIVE_END, VGA_V_TOTAL, d_data));
    check("small_outs",
          64'({s_hsync, s_vsync, s_valid, s_h_addr, s_v_addr, s_r, s_g, s_b}),
          model(t, SH_SYNC, SH_AS, SH_AE, SH_TOT, SV_SYNC, SV_AS, SV_AE, SV_TOT, s_data));
    if (!reset) begin
      measure();
      if (t == LINE0 + 143) begin
        check("edge143_valid", 64'(d_valid), 64'(0));
        check("edge143_h_addr", 64'(d_h_addr), 64'(0));
        check("edge143_rgb", 64'({d_r, d_g, d_b}), 64'(0));
      end
      if (t == LINE0 + 144) begin
        check("edge144_valid", 64'(d_valid), 64'(1));
        check("edge144_addr", 64'({d_h_addr, d_v_addr}), 64'(0));
        check("edge144_rgb", 64'({d_r, d_g, d_b}), 64'(24'hA1B2C3));
      end
      if (t == LINE0 + 783) check("edge783_h_addr", 64'(d_h_addr), 64'(639));
      if (t == LINE0 + 784) check("edge784_valid", 64'(d_valid), 64'(0));
    end
  endtask

  task automatic drive_data();
    if (t >= 34 * 800 && t < 37 * 800) d_data = 24'hA1B2C3;
    else d_data = 24'($urandom);
    s_data = 24'($urandom);
  endtask

  task automatic step();
    @(posedge pclk);
    if (!reset) t++;
    @(negedge pclk);
    drive_data();
    #1;
    sample();
  endtask

  initial begin
    reset  = 1'b1;
    t      = 0;
    d_data = 24'($urandom);
    s_data = 24'($urandom);
    init_meas();
    repeat (3) @(negedge pclk);
    #1;
    sample();

    @(negedge pclk);
    reset = 1'b0;
    drive_data();
    #1;
    sample();
    repeat (37 * 800) step();

    // Asynchronous reset landing between clock edges, partway through a line.
    @(posedge pclk);
    t++;
    #2;
    reset = 1'b1;
    t = 0;
    #1;
    check("async_rst_outs", 64'({d_hsync, d_vsync, d_valid, d_h_addr, d_v_addr, d_r, d_g, d_b}),
          64'(0));
    sample();
    repeat (2) step();

    @(negedge pclk);
    reset = 1'b0;
    drive_data();
    #1;
    init_meas();
    sample();
    step();
    check("resume_h_sync_low", 64'({d_hsync, d_vsync, s_hsync, s_vsync}), 64'(0));
    repeat (1700) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
